// File: rtl/l1_cache_pkg.sv
// Shared definitions for the split L1 cache: op encodings, address geometry,
// and the issue-FSM state/source types used by the L1-to-L2 request queue.
package l1_cache_pkg;

  localparam logic [1:0] OP_DREAD      = 2'd0;
  localparam logic [1:0] OP_DWRITE     = 2'd1;
  localparam logic [1:0] OP_IREAD      = 2'd2;
  localparam logic [1:0] OP_DWRITEBACK = 2'd3;

  localparam int ADDRESS_WIDTH     = 32;
  localparam int BYTE_SELECT_WIDTH = 6;
  localparam int TAG_WIDTH         = 12;
  localparam int INDEX_WIDTH       = 14;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t ISSUE = 1'b1;

  typedef enum logic {
    SRC_RD = 1'b0,
    SRC_WQ = 1'b1
  } src_t;

  // Ops 1 and 3 carry write data; ops 0 and 2 are fills.
  function automatic logic is_write_op(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/l1_wq_cam_fifo.sv
// Write-queue FIFO with per-entry valid bits and two line-address match ports:
// one for write coalescing (optionally ignoring the head) and one for read conflicts.
module l1_wq_cam_fifo #(
  parameter int ADDRESS_WIDTH     = l1_cache_pkg::ADDRESS_WIDTH,
  parameter int BYTE_SELECT_WIDTH = l1_cache_pkg::BYTE_SELECT_WIDTH,
  parameter int WQ_DEPTH          = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       clr,
  input  logic                                       push,
  input  logic [1:0]                                 push_op,
  input  logic [ADDRESS_WIDTH-1:0]                   push_addr,
  input  logic                                       pop,
  output logic [1:0]                                 head_op,
  output logic [ADDRESS_WIDTH-1:0]                   head_addr,
  output logic                                       empty,
  output logic                                       full,
  input  logic [1:0]                                 merge_op,
  input  logic [ADDRESS_WIDTH-BYTE_SELECT_WIDTH-1:0] merge_line,
  input  logic                                       merge_excl_head,
  output logic                                       merge_hit,
  input  logic [ADDRESS_WIDTH-BYTE_SELECT_WIDTH-1:0] conf_line,
  output logic                                       conf_hit
);

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(WQ_DEPTH);

  logic [1:0]               op_r   [WQ_DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_r [WQ_DEPTH];
  logic [WQ_DEPTH-1:0]      vld_r;
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [PTR_W:0]           count_r;
  logic                     push_s;
  logic                     pop_s;

  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign full      = (count_r == CNT_MAX);
  assign push_s    = push && !full;
  assign pop_s     = pop && !empty;
  assign head_op   = op_r[rd_ptr_r];
  assign head_addr = addr_r[rd_ptr_r];

  // Pointer, occupancy and per-entry valid bookkeeping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      vld_r    <= {WQ_DEPTH{1'b0}};
    end else begin
      // Push and pop never address the same slot: that needs empty or full.
      if (push_s) begin
        vld_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        vld_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r        <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      op_r[wr_ptr_r]   <= push_op;
      addr_r[wr_ptr_r] <= push_addr;
    end
  end

  // Line-address comparators for the coalescing and read-conflict ports
  always_comb begin
    merge_hit = 1'b0;
    conf_hit  = 1'b0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      merge_hit = merge_hit |
                  (vld_r[i] &&
                   (addr_r[i][ADDRESS_WIDTH-1:BYTE_SELECT_WIDTH] == merge_line) &&
                   (op_r[i] == merge_op) &&
                   !(merge_excl_head && (PTR_W'(i) == rd_ptr_r)));
      conf_hit  = conf_hit |
                  (vld_r[i] &&
                   (addr_r[i][ADDRESS_WIDTH-1:BYTE_SELECT_WIDTH] == conf_line));
    end
  end

endmodule

// File: rtl/l1_l2_request_queue.sv
// L1-to-L2 request queue: one read slot plus a coalescing write FIFO, issued
// over a single valid/ready channel with reads bypassing non-conflicting writes.
module l1_l2_request_queue #(
  parameter int ADDRESS_WIDTH     = l1_cache_pkg::ADDRESS_WIDTH,
  parameter int BYTE_SELECT_WIDTH = l1_cache_pkg::BYTE_SELECT_WIDTH,
  parameter int WQ_DEPTH          = 8,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     l2_valid,
  input  logic                     l2_ready,
  output logic [1:0]               l2_op,
  output logic [ADDRESS_WIDTH-1:0] l2_addr,
  output logic [CNT_WIDTH-1:0]     stat_reads,
  output logic [CNT_WIDTH-1:0]     stat_writes,
  output logic [CNT_WIDTH-1:0]     stat_merged
);

  import l1_cache_pkg::*;

  localparam int LINE_W = ADDRESS_WIDTH - BYTE_SELECT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                     rd_valid_r;
  logic [1:0]               rd_op_r;
  logic [ADDRESS_WIDTH-1:0] rd_addr_r;
  state_t                   state_r;
  src_t                     src_r;
  logic                     l2_valid_r;
  logic [1:0]               l2_op_r;
  logic [ADDRESS_WIDTH-1:0] l2_addr_r;
  logic [CNT_WIDTH-1:0]     stat_reads_r;
  logic [CNT_WIDTH-1:0]     stat_writes_r;
  logic [CNT_WIDTH-1:0]     stat_merged_r;

  logic                     wq_full_s;
  logic                     wq_empty_s;
  logic [1:0]               wq_head_op_s;
  logic [ADDRESS_WIDTH-1:0] wq_head_addr_s;
  logic                     merge_hit_s;
  logic                     conf_hit_s;
  logic                     req_ready_s;
  logic                     accept_s;
  logic                     is_wr_s;
  logic                     push_s;
  logic                     merged_s;
  logic                     handshake_s;
  logic                     wq_pop_s;
  logic                     rd_pop_s;
  logic                     excl_head_s;
  logic                     load_rd_s;
  logic                     load_wq_s;

  // Occupancy is taken before any same-cycle pop, so ready is conservative.
  assign req_ready_s = !rd_valid_r && !wq_full_s;
  assign accept_s    = req_valid && req_ready_s;
  assign is_wr_s     = is_write_op(req_op);
  assign push_s      = accept_s && is_wr_s && !merge_hit_s;
  assign merged_s    = accept_s && is_wr_s && merge_hit_s;
  assign handshake_s = l2_valid_r && l2_ready;
  assign wq_pop_s    = handshake_s && (src_r == SRC_WQ);
  assign rd_pop_s    = handshake_s && (src_r == SRC_RD);
  // The presented head is already committed to L2, so it must not absorb a new write.
  assign excl_head_s = (state_r == ISSUE) && (src_r == SRC_WQ);
  assign load_rd_s   = (state_r == IDLE) && rd_valid_r && !conf_hit_s;
  assign load_wq_s   = (state_r == IDLE) && !load_rd_s && !wq_empty_s;

  l1_wq_cam_fifo #(
    .ADDRESS_WIDTH    (ADDRESS_WIDTH),
    .BYTE_SELECT_WIDTH(BYTE_SELECT_WIDTH),
    .WQ_DEPTH         (WQ_DEPTH)
  ) u_wq (
    .clk            (clk),
    .rst            (rst),
    .clr            (flush),
    .push           (push_s),
    .push_op        (req_op),
    .push_addr      (req_addr),
    .pop            (wq_pop_s),
    .head_op        (wq_head_op_s),
    .head_addr      (wq_head_addr_s),
    .empty          (wq_empty_s),
    .full           (wq_full_s),
    .merge_op       (req_op),
    .merge_line     (req_addr[ADDRESS_WIDTH-1:BYTE_SELECT_WIDTH]),
    .merge_excl_head(excl_head_s),
    .merge_hit      (merge_hit_s),
    .conf_line      (rd_addr_r[ADDRESS_WIDTH-1:BYTE_SELECT_WIDTH]),
    .conf_hit       (conf_hit_s)
  );

  // Single pending read fill
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_valid_r <= 1'b0;
      rd_op_r    <= 2'd0;
      rd_addr_r  <= {ADDRESS_WIDTH{1'b0}};
    end else if (accept_s && !is_wr_s) begin
      rd_valid_r <= 1'b1;
      rd_op_r    <= req_op;
      rd_addr_r  <= req_addr;
    end else if (rd_pop_s) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_valid_r;
    end
  end

  // Issue FSM and the registered L2 request
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_r    <= IDLE;
      src_r      <= SRC_RD;
      l2_valid_r <= 1'b0;
      l2_op_r    <= 2'd0;
      l2_addr_r  <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (load_rd_s) begin
            state_r    <= ISSUE;
            src_r      <= SRC_RD;
            l2_valid_r <= 1'b1;
            l2_op_r    <= rd_op_r;
            l2_addr_r  <= rd_addr_r;
          end else if (load_wq_s) begin
            state_r    <= ISSUE;
            src_r      <= SRC_WQ;
            l2_valid_r <= 1'b1;
            l2_op_r    <= wq_head_op_s;
            l2_addr_r  <= wq_head_addr_s;
          end else begin
            state_r    <= IDLE;
            l2_valid_r <= 1'b0;
          end
        end
        ISSUE: begin
          if (handshake_s) begin
            state_r    <= IDLE;
            l2_valid_r <= 1'b0;
          end else begin
            state_r    <= ISSUE;
            l2_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          l2_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Statistics counters; a coalesced write still counts as an accepted write
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stat_reads_r  <= {CNT_WIDTH{1'b0}};
      stat_writes_r <= {CNT_WIDTH{1'b0}};
      stat_merged_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (accept_s && !is_wr_s) begin
        stat_reads_r <= stat_reads_r + STAT_ONE;
      end
      if (accept_s && is_wr_s) begin
        stat_writes_r <= stat_writes_r + STAT_ONE;
      end
      if (merged_s) begin
        stat_merged_r <= stat_merged_r + STAT_ONE;
      end
    end
  end

  assign req_ready   = req_ready_s;
  assign l2_valid    = l2_valid_r;
  assign l2_op       = l2_op_r;
  assign l2_addr     = l2_addr_r;
  assign stat_reads  = stat_reads_r;
  assign stat_writes = stat_writes_r;
  assign stat_merged = stat_merged_r;

endmodule
